// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit type encoding, port indices and a flit-type helper.
package noc_pkg;

    localparam int unsigned FLIT_TYPE_W = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        BODY      = 2'b00,
        TAIL      = 2'b01,
        HEAD      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_t;

    localparam int unsigned PORT_N = 0;
    localparam int unsigned PORT_E = 1;
    localparam int unsigned PORT_S = 2;
    localparam int unsigned PORT_W = 3;
    localparam int unsigned PORT_L = 4;

    // Flit is passed zero-extended; width selects where the type field sits.
    function automatic flit_type_t flit_type(input logic [63:0] flit, input int unsigned width);
        return flit_type_t'(flit[width-1 -: FLIT_TYPE_W]);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, searching cyclically.
module rr_arbiter #(
    parameter int unsigned PORTS = 5,
    parameter int unsigned PTR_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PORTS-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             valid
);

    always_comb begin
        int cand;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = 0;
        for (int k = 0; k < int'(PORTS); k++) begin
            cand = (int'(ptr) + k) % int'(PORTS);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output wormhole arbiter: round-robin head grant, head-to-tail lock, registered flit mux.
module output_port_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned LINK_WIDTH = 8,
    parameter int unsigned PORTS      = 5,
    parameter int unsigned PTR_W      = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            req,
    input  logic [PORTS*LINK_WIDTH-1:0] in_flits,
    input  logic                        on_off,
    output logic [PORTS-1:0]            rd_en,
    output logic [LINK_WIDTH-1:0]       out_flit,
    output logic                        out_wr_en,
    output logic                        busy,
    output logic [PTR_W-1:0]            owner,
    output logic                        proto_err
);

    typedef enum logic [0:0] {StIdle, StLocked} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             err_q, err_d;
    logic [PTR_W-1:0] sel;

    logic [LINK_WIDTH-1:0] flit_arr [PORTS];
    flit_type_t            ftype    [PORTS];
    logic [PORTS-1:0]      is_head;

    for (genvar i = 0; i < int'(PORTS); i++) begin : g_slice
        assign flit_arr[i] = in_flits[i*LINK_WIDTH +: LINK_WIDTH];
        assign ftype[i]    = flit_type(64'(flit_arr[i]), LINK_WIDTH);
        assign is_head[i]  = (ftype[i] == HEAD) || (ftype[i] == HEAD_TAIL);
    end

    logic [PORTS-1:0] arb_grant;
    logic [PTR_W-1:0] arb_idx;
    logic             arb_valid;

    rr_arbiter #(
        .PORTS(PORTS),
        .PTR_W(PTR_W)
    ) u_rr_arbiter (
        .req      (req & is_head),
        .ptr      (ptr_q),
        .grant    (arb_grant),
        .grant_idx(arb_idx),
        .valid    (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        rd_en   = '0;
        sel     = owner_q;
        case (state_q)
            StIdle: begin
                // Body/tail at the front with no lock means a head was lost upstream.
                if (|(req & ~is_head)) err_d = 1'b1;
                if (on_off && arb_valid) begin
                    rd_en = arb_grant;
                    sel   = arb_idx;
                    ptr_d = (arb_idx == PTR_W'(PORTS - 1)) ? '0 : arb_idx + 1'b1;
                    if (ftype[arb_idx] == HEAD) begin
                        state_d = StLocked;
                        owner_d = arb_idx;
                    end
                end
            end
            StLocked: begin
                if (req[owner_q]) begin
                    if (is_head[owner_q]) begin
                        err_d = 1'b1;
                    end else if (on_off) begin
                        rd_en[owner_q] = 1'b1;
                        if (ftype[owner_q] == TAIL) state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst) rd_en = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= '0;
            ptr_q     <= '0;
            err_q     <= 1'b0;
            out_flit  <= '0;
            out_wr_en <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            out_wr_en <= |rd_en;
            if (|rd_en) out_flit <= flit_arr[sel];
        end
    end

    assign busy      = (state_q == StLocked);
    assign owner     = owner_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter; forwarded flits are checked against a scoreboard queue.
module tb_output_port_arbiter;

    localparam int unsigned LW = 8;
    localparam int unsigned NP = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] req;
    logic [NP*LW-1:0] in_flits;
    logic          on_off;
    logic [NP-1:0] rd_en;
    logic [LW-1:0] out_flit;
    logic          out_wr_en;
    logic          busy;
    logic [2:0]    owner;
    logic          proto_err;

    logic [LW-1:0] fl [NP];
    logic [LW-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        in_flits = '0;
        for (int i = 0; i < int'(NP); i++) in_flits[i*LW +: LW] = fl[i];
    end

    output_port_arbiter #(
        .LINK_WIDTH(LW),
        .PORTS     (NP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .in_flits (in_flits),
        .on_off   (on_off),
        .rd_en    (rd_en),
        .out_flit (out_flit),
        .out_wr_en(out_wr_en),
        .busy     (busy),
        .owner    (owner),
        .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every written flit must match the oldest expected one.
    always @(negedge clk) begin
        if (out_wr_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL sb_unexpected got=%0h exp=none", out_flit);
            end else begin
                logic [LW-1:0] e;
                e = exp_q.pop_front();
                assert (out_flit === e) else begin
                    bad++;
                    $error("FAIL sb_flit got=%0h exp=%0h", out_flit, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; on_off = 1'b0;
        for (int i = 0; i < int'(NP); i++) fl[i] = '0;
        tick();
        req = 5'b00100; fl[2] = 8'hC5; on_off = 1'b1;
        #1 chk("rd_en_in_rst", 32'(rd_en), 32'h0);
        req = '0;
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_wr_en", 32'(out_wr_en), 32'h0);
        chk("rst_flit", 32'(out_flit), 32'h0);
        chk("rst_err", 32'(proto_err), 32'h0);

        // Single-flit packet from input 2
        req = 5'b00100; fl[2] = 8'hC5;
        #1 chk("single_rd", 32'(rd_en), 32'b00100);
        exp_q.push_back(8'hC5);
        tick();
        req = '0;
        chk("single_wr", 32'(out_wr_en), 32'h1);
        chk("single_busy", 32'(busy), 32'h0);

        // 4-flit packet from input 1; input 3 joins with a head once 1 owns the link
        req = 5'b00010; fl[1] = 8'h81;
        #1 chk("pkt_head_rd", 32'(rd_en), 32'b00010);
        exp_q.push_back(8'h81);
        tick();
        req = 5'b01010; fl[1] = 8'h02; fl[3] = 8'h8A;
        #1 chk("pkt_b1_rd", 32'(rd_en), 32'b00010);
        chk("pkt_busy", 32'(busy), 32'h1);
        chk("pkt_owner", 32'(owner), 32'h1);
        exp_q.push_back(8'h02);
        tick();
        fl[1] = 8'h03;
        #1 chk("pkt_b2_rd", 32'(rd_en), 32'b00010);
        exp_q.push_back(8'h03);
        tick();
        fl[1] = 8'h44;
        #1 chk("pkt_tail_rd", 32'(rd_en), 32'b00010);
        exp_q.push_back(8'h44);
        tick();
        req = 5'b01000;
        #1 chk("next_head_rd", 32'(rd_en), 32'b01000);
        chk("next_idle", 32'(busy), 32'h0);
        chk("no_gap_wr", 32'(out_wr_en), 32'h1);
        exp_q.push_back(8'h8A);
        tick();
        chk("no_gap_wr2", 32'(out_wr_en), 32'h1);
        chk("owner3", 32'(owner), 32'h3);

        // Backpressure mid-packet
        fl[3] = 8'h0B;
        #1 chk("bp_pre_rd", 32'(rd_en), 32'b01000);
        exp_q.push_back(8'h0B);
        tick();
        on_off = 1'b0; fl[3] = 8'h0C;
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_rd", 32'(rd_en), 32'h0);
            chk("bp_busy", 32'(busy), 32'h1);
            tick();
            chk("bp_wr", 32'(out_wr_en), 32'h0);
        end
        on_off = 1'b1;
        #1 chk("bp_resume_rd", 32'(rd_en), 32'b01000);
        exp_q.push_back(8'h0C);
        tick();
        fl[3] = 8'h0D;
        exp_q.push_back(8'h0D);
        tick();

        // Underrun: owner buffer empty for two cycles
        req = '0;
        for (int c = 0; c < 2; c++) begin
            #1 chk("ur_rd", 32'(rd_en), 32'h0);
            chk("ur_busy", 32'(busy), 32'h1);
            chk("ur_owner", 32'(owner), 32'h3);
            tick();
            chk("ur_wr", 32'(out_wr_en), 32'h0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_wr", 32'(out_wr_en), 32'h0);

        // Fairness: every input holds a single-flit packet; pointer restarts at 0
        req = 5'b11111;
        for (int i = 0; i < int'(NP); i++) fl[i] = 8'hC0 | 8'(i);
        for (int k = 0; k < 6; k++) begin
            #1 chk("rr_rd", 32'(rd_en), 32'(1) << (k % 5));
            exp_q.push_back(8'hC0 | 8'(k % 5));
            tick();
        end
        req = '0;
        tick();

        // Protocol error: body at the front while idle
        req = 5'b00001; fl[0] = 8'h05;
        #1 chk("perr_rd0", 32'(rd_en), 32'h0);
        chk("perr_pre", 32'(proto_err), 32'h0);
        tick();
        chk("perr_set", 32'(proto_err), 32'h1);
        req = '0;
        tick();
        tick();
        chk("perr_held", 32'(proto_err), 32'h1);
        chk("perr_nowr", 32'(out_wr_en), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("perr_clr", 32'(proto_err), 32'h0);
        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
Per-output-port wormhole arbiter and crossbar-column controller for the 5-port mesh router. It receives requests from all input buffers whose head flit routes to this output and picks one by round-robin. The output is then locked to that input from head flit to tail flit. While locked, it pops the owner's buffer, muxes its flit onto the output link and drives the downstream write enable, gated by the downstream ON/OFF flow-control signal. One instance is used per output port.

Parameters:
LINK_WIDTH, 8, flit width in bits; the top 2 bits carry the flit type.
PORTS, 5, number of input ports competing (0=N, 1=E, 2=S, 3=W, 4=Local).
PTR_W, $clog2(PORTS), width of the owner index and the round-robin pointer.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  PORTS  req[i]=1: input buffer i is non-empty and its front flit routes to this output
in_flits  input  PORTS*LINK_WIDTH  front flit of each input buffer; slice i = in_flits[i*LINK_WIDTH +: LINK_WIDTH]
on_off  input  1  downstream flow control; 1 = may send, 0 = stop
rd_en  output  PORTS  one-hot, combinational pop to the granted input buffer
out_flit  output  LINK_WIDTH  registered flit on the output link
out_wr_en  output  1  registered write enable to the downstream buffer
busy  output  1  1 while the output is locked to a packet
owner  output  PTR_W  index of the locked input; valid when busy=1
proto_err  output  1  sticky error flag

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, rr_ptr=0, owner=0, busy=0, out_flit=0, out_wr_en=0, proto_err=0. rd_en=0 while rst=1. Reset mid-packet drops the lock immediately.
- Flit type in bits [LINK_WIDTH-1:LINK_WIDTH-2]:
  - 2'b10 = HEAD
  - 2'b00 = BODY
  - 2'b01 = TAIL
  - 2'b11 = HEAD_TAIL (single-flit packet)
- State IDLE:
  - Eligible inputs: req[i]=1 and type(i) ∈ {HEAD, HEAD_TAIL}.
  - If on_off=1 and any input is eligible: grant the first eligible index at or after rr_ptr, searching cyclically. Assert rd_en[g] in the same cycle.
  - On a HEAD grant: go to LOCKED, owner<=g.
  - On a HEAD_TAIL grant: stay in IDLE.
  - On either grant type: rr_ptr<=(g+1) mod PORTS.
  - If on_off=0: no grant and no state change.
- State LOCKED:
  - Only the owner is serviced. rd_en[owner]=req[owner]&on_off; all other rd_en bits are 0.
  - When the forwarded flit is TAIL: go to IDLE next cycle. The pointer was already advanced at the head.
  - If req[owner]=0 (buffer underrun): hold the lock, insert a bubble, out_wr_en=0.
- Datapath latency: 1 cycle.
  - When rd_en[g]=1 at cycle t: at edge t+1, out_flit<=flit(g) and out_wr_en<=1.
  - Otherwise out_wr_en<=0 and out_flit holds its value.
- Protocol errors set proto_err, which stays set until rst:
  - In IDLE: req[i]=1 with a BODY or TAIL front flit. That input is never granted.
  - In LOCKED: the owner presents HEAD or HEAD_TAIL. It is not forwarded and the lock holds.
- Back-to-back packets: a tail forwarded in cycle t allows a new head grant in cycle t+1, giving no dead cycle on the link.
- on_off is sampled combinationally each cycle. The upstream already registers full→ON/OFF, so the 1-cycle in-flight flit is absorbed by downstream buffer slack.
- rd_en has at most one bit set at any time. It is never asserted for an input with req=0.

Decomposition:
- Package noc_pkg holds:
  - flit_type_t enum {BODY=2'b00, TAIL=2'b01, HEAD=2'b10, HEAD_TAIL=2'b11}
  - constant FLIT_TYPE_W=2
  - helper function flit_type(flit) returning the top 2 bits
  - port index constants PORT_N..PORT_L
- Sub-module rr_arbiter (PORTS-wide, combinational grant from req and ptr, one-hot plus index outputs). It is reused by the switch allocator. State, lock, mux and output registers stay in output_port_arbiter.

Test Plan:
- Single-flit packet: after reset, req=5'b00100, in2=8'hC5, on_off=1 → rd_en=5'b00100 for 1 cycle; next cycle out_flit=8'hC5, out_wr_en=1; busy stays 0; rr_ptr=3.
- 4-flit packet from input 1 (8'h81, 8'h02, 8'h03, 8'h44) while input 3 also requests a HEAD → rd_en stays on bit 1 for 4 cycles, busy=1, owner=1; input 3 is granted in the cycle after the tail, with no link gap.
- Round-robin fairness: all 5 inputs present HEAD_TAIL continuously, on_off=1 → grant order 0,1,2,3,4,0; each input gets 1 of every 5 grants.
- Backpressure: mid-packet, on_off=0 for 3 cycles → rd_en=0 and out_wr_en=0 for those cycles, lock held; the remaining flits follow in order after on_off=1.
- Underrun and reset: owner req drops for 2 cycles mid-packet → bubbles with the lock held. Then assert rst=1 for 1 cycle → busy=0, out_wr_en=0, rr_ptr=0 at the next edge.
- Protocol error: in IDLE, req=5'b00001 with in0=8'h05 (BODY) → no grant, proto_err=1 from the next cycle and held until rst.
